rect_mag_iter: RTL and testbench

//  Parametrised rectangular-to-cylindrical magnitude unit: r = sqrt(x^2 + y^2).
//  - Exact digit-by-digit integer square root, one result bit per cycle.
//  - Optional signed inputs and round-to-nearest.
//  - valid/ready handshakes on input and output.
//  - Sits between the coordinate source and downstream consumers of r.

---
 rtl/rect_mag_iter_if.sv | 31 +++
 rtl/rect_mag_iter.sv | 159 +++++++++++++++
 tb/tb_rect_mag_iter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rect_mag_iter_if.sv
// rect_mag_iter_if
//   Operand and result handshake bundle for the rect_mag_iter magnitude unit.
//   Ports (signals):
//     in_valid / in_ready    operand pair handshake
//     x_in, y_in     [W-1:0] operand coordinates
//     out_valid / out_ready  result handshake
//     r_out          [W:0]   magnitude sqrt(x^2 + y^2)
//     r_sq_out       [2W:0]  exact x^2 + y^2
//   Modports: master = coordinate source / result consumer, slave = the unit.
interface rect_mag_iter_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x_in;
  logic [W-1:0]   y_in;
  logic           out_valid;
  logic           out_ready;
  logic [W:0]     r_out;
  logic [2*W:0]   r_sq_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, r_out, r_sq_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, r_out, r_sq_out
  );
endinterface

// File: rtl/rect_mag_iter.sv
// rect_mag_iter
//   Iterative rectangular-to-cylindrical magnitude: r = sqrt(x^2 + y^2).
//   One SQUARE cycle forms S = |x|^2 + |y|^2, then an exact digit-by-digit
//   square root produces one result bit per cycle over W+1 ROOT cycles.
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     ena     1: advance, 0: freeze all state and block both handshakes
//     bus     rect_mag_iter_if.slave (operand and result handshakes)
//     busy    high whenever the FSM is not IDLE
//   Parameters:
//     W          operand width
//     SIGNED_IN  operands are two's complement; magnitudes are squared
//     ROUND      0: floor(sqrt(S)), 1: round to nearest
module rect_mag_iter #(
  parameter int W         = 8,
  parameter bit SIGNED_IN = 1'b0,
  parameter bit ROUND     = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  rect_mag_iter_if.slave  bus,
  output logic            busy
);

  localparam int SW = 2 * W + 1;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    ROOT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [W-1:0]    ax;
  logic [W-1:0]    ay;
  logic [SW-1:0]   sq;
  logic [SW:0]     sh;
  logic [W:0]      root;
  logic [W+1:0]    rem;
  logic [CW-1:0]   cnt;
  logic [W:0]      r_reg;
  logic [SW-1:0]   r_sq_reg;

  logic            accept;
  logic            consume;
  logic            last_iter;
  logic [SW-1:0]   s_calc;
  logic [1:0]      pair;
  logic [W+3:0]    shifted;
  logic [W+3:0]    subtr;
  logic [W+4:0]    diff;
  logic            neg;
  logic [W+1:0]    rem_nxt;
  logic [W:0]      root_nxt;
  logic [W:0]      r_round;

  // -2^(W-1) maps to 2^(W-1), which still fits in W unsigned bits.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    if (SIGNED_IN && v[W-1])
      return (~v) + {{(W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  assign bus.in_ready  = ena & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign bus.out_valid = (state == DONE);
  assign bus.r_out     = r_reg;
  assign bus.r_sq_out  = r_sq_reg;
  assign busy          = (state != IDLE);

  assign accept    = bus.in_valid & bus.in_ready;
  assign consume   = ena & (state == DONE) & bus.out_ready;
  assign last_iter = (cnt == '0);

  assign s_calc = ({{(W+1){1'b0}}, ax} * {{(W+1){1'b0}}, ax})
                + ({{(W+1){1'b0}}, ay} * {{(W+1){1'b0}}, ay});

  // One root iteration: bring down the next bit pair of S and try to
  // subtract (root << 2 | 1). The extra top bit of diff is the borrow.
  assign pair     = sh[SW -: 2];
  assign shifted  = {rem, pair};
  assign subtr    = {1'b0, root, 2'b01};
  assign diff     = {1'b0, shifted} - {1'b0, subtr};
  assign neg      = diff[W+4];
  assign rem_nxt  = neg ? shifted[W+1:0] : diff[W+1:0];
  assign root_nxt = {root[W-1:0], ~neg};

  // With rem = S - root^2, rem > root means S is closer to (root+1)^2.
  assign r_round = (ROUND && (rem_nxt > {1'b0, root_nxt}))
                 ? root_nxt + {{W{1'b0}}, 1'b1}
                 : root_nxt;

  // State register; a low ena holds the FSM exactly where it is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else if (ena)
      state <= state_nxt;
  end

  // Next-state logic; a consume in DONE can coincide with a new accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SQUARE;
      SQUARE:  state_nxt = ROOT;
      ROOT:    if (last_iter) state_nxt = DONE;
      DONE:    if (consume) state_nxt = accept ? SQUARE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, square, iterate the root, and
  // register the result on the final ROOT cycle so it appears with DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax       <= '0;
      ay       <= '0;
      sq       <= '0;
      sh       <= '0;
      root     <= '0;
      rem      <= '0;
      cnt      <= '0;
      r_reg    <= '0;
      r_sq_reg <= '0;
    end else if (ena) begin
      if (accept) begin
        ax <= magnitude(bus.x_in);
        ay <= magnitude(bus.y_in);
      end
      case (state)
        SQUARE: begin
          sq   <= s_calc;
          sh   <= {1'b0, s_calc};
          root <= '0;
          rem  <= '0;
          cnt  <= CW'(W);
        end
        ROOT: begin
          sh   <= sh << 2;
          root <= root_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt - 1'b1;
          if (last_iter) begin
            r_reg    <= r_round;
            r_sq_reg <= sq;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_mag_iter.sv
// tb_rect_mag_iter
//   Self-checking bench for rect_mag_iter. Three instances share one
//   stimulus stream: unsigned/floor, unsigned/round, signed/floor. Each
//   accepted operand pair pushes a model result per instance onto its
//   scoreboard queue; results are popped and compared when out_valid rises.
//   Ports: none (top level).
module tb_rect_mag_iter;

  localparam int W = 8;

  typedef struct {
    logic [W:0]   r;
    logic [2*W:0] s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         busy0, busy1, busy2;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int accept_cyc = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rect_mag_iter_if #(.W(W)) if0 ();
  rect_mag_iter_if #(.W(W)) if1 ();
  rect_mag_iter_if #(.W(W)) if2 ();

  assign if0.in_valid  = in_valid;
  assign if0.x_in      = x;
  assign if0.y_in      = y;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.x_in      = x;
  assign if1.y_in      = y;
  assign if1.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.x_in      = x;
  assign if2.y_in      = y;
  assign if2.out_ready = out_ready;

  rect_mag_iter #(.W(W), .SIGNED_IN(1'b0), .ROUND(1'b0)) u_floor (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(if0), .busy(busy0)
  );

  rect_mag_iter #(.W(W), .SIGNED_IN(1'b0), .ROUND(1'b1)) u_round (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(if1), .busy(busy1)
  );

  rect_mag_iter #(.W(W), .SIGNED_IN(1'b1), .ROUND(1'b0)) u_signed (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(if2), .busy(busy2)
  );

  // Reference: smallest r with (r+1)^2 > S, optionally moved to the nearer square.
  function automatic exp_t model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                 input bit sgn, input bit rnd);
    exp_t e;
    int ax, ay, s, r;
    ax = (sgn && xv[W-1]) ? (1 << W) - int'(xv) : int'(xv);
    ay = (sgn && yv[W-1]) ? (1 << W) - int'(yv) : int'(yv);
    s = ax * ax + ay * ay;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    if (rnd && (((r + 1) * (r + 1) - s) < (s - r * r))) r++;
    e.r = r[W:0];
    e.s = s[2*W:0];
    return e;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Hold operands until the unit accepts them, then record the accept cycle
  // and push the expected results; operands are scrambled afterwards.
  task automatic applyStimulus(input logic [W-1:0] xv, input logic [W-1:0] yv);
    int n;
    n = 0;
    x = xv;
    y = yv;
    in_valid = 1'b1;
    while (!if0.in_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkVal("accept_ready", 32'(if0.in_ready), 1);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    q0.push_back(model(xv, yv, 1'b0, 1'b0));
    q1.push_back(model(xv, yv, 1'b0, 1'b1));
    q2.push_back(model(xv, yv, 1'b1, 1'b0));
    in_valid = 1'b0;
    x = W'($urandom);
    y = W'($urandom);
  endtask

  // Wait (bounded) for out_valid, check latency, then pop and compare.
  task automatic checkOutput(input string tag, input int lat);
    int n;
    exp_t e;
    n = 0;
    while (!if0.out_valid && n < lat + 20) begin
      @(negedge clk);
      n++;
    end
    checkVal({tag, ".valid"}, 32'(if0.out_valid & if1.out_valid & if2.out_valid), 1);
    checkVal({tag, ".latency"}, cyc - accept_cyc, lat);
    checkVal({tag, ".sb"}, 32'(q0.size() > 0 && q1.size() > 0 && q2.size() > 0), 1);
    if (q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
      e = q0.pop_front();
      checkVal({tag, ".floor.r"}, 32'(if0.r_out), 32'(e.r));
      checkVal({tag, ".floor.sq"}, 32'(if0.r_sq_out), 32'(e.s));
      e = q1.pop_front();
      checkVal({tag, ".round.r"}, 32'(if1.r_out), 32'(e.r));
      checkVal({tag, ".round.sq"}, 32'(if1.r_sq_out), 32'(e.s));
      e = q2.pop_front();
      checkVal({tag, ".signed.r"}, 32'(if2.r_out), 32'(e.r));
      checkVal({tag, ".signed.sq"}, 32'(if2.r_sq_out), 32'(e.s));
    end
  endtask

  task automatic consumeResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkVal({tag, ".drop"}, 32'(if0.out_valid | if1.out_valid | if2.out_valid), 0);
    checkVal({tag, ".idle"}, 32'(busy0 | busy1 | busy2), 0);
  endtask

  initial begin
    int seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst.valid", 32'(if0.out_valid | if1.out_valid | if2.out_valid), 0);
    checkVal("rst.busy", 32'(busy0 | busy1 | busy2), 0);
    checkVal("rst.r", 32'(if0.r_out | if1.r_out | if2.r_out), 0);
    checkVal("rst.sq", 32'(if0.r_sq_out | if1.r_sq_out | if2.r_sq_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkVal("rst.ready", 32'(if0.in_ready), 1);

    // Basic and boundary operands
    applyStimulus(8'd3, 8'd4);
    checkOutput("t1", 10);
    consumeResult("t1");
    applyStimulus(8'd255, 8'd255);
    checkOutput("t2max", 10);
    consumeResult("t2max");
    applyStimulus(8'd1, 8'd1);
    checkOutput("t2one", 10);
    consumeResult("t2one");
    applyStimulus(8'h80, 8'h00);
    checkOutput("t3min", 10);
    consumeResult("t3min");
    applyStimulus(8'hFD, 8'hFC);
    checkOutput("t3neg", 10);
    consumeResult("t3neg");
    applyStimulus(8'd0, 8'd0);
    checkOutput("t3zero", 10);
    consumeResult("t3zero");

    // Output stall, then consume and accept on the same edge
    applyStimulus(8'd12, 8'd5);
    checkOutput("t4", 10);
    x = 8'd6;
    y = 8'd8;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkVal("t4.hold_valid", 32'(if0.out_valid), 1);
      checkVal("t4.hold_r", 32'(if0.r_out), 13);
      checkVal("t4.hold_sq", 32'(if0.r_sq_out), 169);
      checkVal("t4.hold_ready", 32'(if0.in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(8'd6, 8'd8);
    out_ready = 1'b0;
    checkVal("t4.b2b_valid", 32'(if0.out_valid), 0);
    checkVal("t4.b2b_busy", 32'(busy0), 1);
    checkOutput("t4b", 10);
    consumeResult("t4b");

    // ena low for 3 cycles mid-ROOT
    applyStimulus(8'd5, 8'd12);
    repeat (4) @(posedge clk);
    #1;
    ena = 1'b0;
    checkVal("t5.ready", 32'(if0.in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    ena = 1'b1;
    checkOutput("t5", 13);
    consumeResult("t5");

    // Reset mid-ROOT discards the operation
    applyStimulus(8'd200, 8'd100);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkVal("t6.valid", 32'(if0.out_valid | if1.out_valid | if2.out_valid), 0);
    checkVal("t6.busy", 32'(busy0 | busy1 | busy2), 0);
    void'(q0.pop_back());
    void'(q1.pop_back());
    void'(q2.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    checkVal("t6.ready", 32'(if0.in_ready), 1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (if0.out_valid | if1.out_valid | if2.out_valid) seen++;
    end
    checkVal("t6.no_stale", seen, 0);
    applyStimulus(8'd6, 8'd8);
    checkOutput("t6", 10);
    consumeResult("t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
